// File: rtl/counter32_pkg.sv
// Shared types and constants for the 32-bit counter stimulus sequencer.
// Modo codes, sequencer states and the LFSR polynomial live here.
package counter32_pkg;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DN   = 2'b01;
  localparam logic [1:0] MODO_DN3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_LD_HI = 3'd2,
    ST_UP    = 3'd3,
    ST_LD_LO = 3'd4,
    ST_DOWN  = 3'd5,
    ST_DOWN3 = 3'd6,
    ST_RAND  = 3'd7
  } state_t;

  // Galois right-shift step
  function automatic logic [31:0] lfsr_next(
    input logic [31:0] l
  );
    return {1'b0, l[31:1]} ^
           (l[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/counter32_stimgen_lfsr32.sv
// 32-bit Galois LFSR with seed load; an all-zero seed would lock up,
// so it is replaced by the init value.
module lfsr32
  import counter32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] q
);

  logic [31:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= LFSR_INIT;
    end else if (load) begin
      r_q <= (seed == 32'h0) ? LFSR_INIT : seed;
    end else if (advance) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/counter32_stimgen.sv
// Stimulus sequencer for the 32-bit counter: reset, load/up, load/down,
// down-by-3, then LFSR traffic, ending with a one-cycle done pulse.
module counter32_stimgen
  import counter32_pkg::*;
#(
  parameter int unsigned RST_LEN   = 2,
  parameter int unsigned PHASE_LEN = 8,
  parameter int unsigned RAND_LEN  = 64,
  parameter logic [31:0] LOAD_HI   = 32'hFFFF_FFFC,
  parameter logic [31:0] LOAD_LO   = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic        hold,
  output logic [31:0] D,
  output logic [1:0]  modo,
  output logic        enable,
  output logic        dut_reset,
  output logic        busy,
  output logic        done,
  output logic [2:0]  phase
);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_d;
  logic [1:0]  r_modo;
  logic        r_en;
  logic        r_rst;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_phase;

  state_t      w_succ;
  state_t      w_ns;
  logic [15:0] w_len;
  logic        w_last;
  logic        w_load;
  logic        w_run;
  logic        w_adv;
  logic [31:0] w_lfsr;

  always_comb begin
    w_len  = 16'd1;
    w_succ = ST_IDLE;
    unique case (r_state)
      ST_IDLE: begin
        w_len  = 16'd1;
        w_succ = ST_RST;
      end
      ST_RST: begin
        w_len  = 16'(RST_LEN);
        w_succ = ST_LD_HI;
      end
      ST_LD_HI: begin
        w_len  = 16'd1;
        w_succ = ST_UP;
      end
      ST_UP: begin
        w_len  = 16'(PHASE_LEN);
        w_succ = ST_LD_LO;
      end
      ST_LD_LO: begin
        w_len  = 16'd1;
        w_succ = ST_DOWN;
      end
      ST_DOWN: begin
        w_len  = 16'(PHASE_LEN);
        w_succ = ST_DOWN3;
      end
      ST_DOWN3: begin
        w_len  = 16'(PHASE_LEN);
        w_succ = ST_RAND;
      end
      ST_RAND: begin
        w_len  = 16'(RAND_LEN);
        w_succ = ST_IDLE;
      end
      default: begin
        w_len  = 16'd1;
        w_succ = ST_IDLE;
      end
    endcase
  end

  assign w_last = (r_cnt == w_len - 16'd1);
  assign w_load = (r_state == ST_IDLE) && start;
  assign w_run  = (r_state != ST_IDLE) && !hold;

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    w_ns = r_state;
    if (w_load) begin
      w_ns = ST_RST;
    end else if (w_run && w_last) begin
      w_ns = w_succ;
    end
  end

  assign w_adv = w_run && (w_ns == ST_RAND);

  lfsr32 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .seed    (seed),
    .advance (w_adv),
    .q       (w_lfsr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_d     <= 32'h0;
      r_modo  <= MODO_UP;
      r_en    <= 1'b0;
      r_rst   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_phase <= 3'd0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && hold) begin
        r_en <= 1'b0;
      end else if (w_load || w_run) begin
        r_state <= w_ns;
        r_cnt   <= (w_load || w_last) ? 16'd0
                                      : r_cnt + 16'd1;
        r_phase <= w_ns;
        r_busy  <= (w_ns != ST_IDLE);
        unique case (w_ns)
          ST_IDLE: begin
            r_done <= 1'b1;
            r_en   <= 1'b0;
            r_rst  <= 1'b0;
            r_modo <= MODO_UP;
            r_d    <= 32'h0;
          end
          ST_RST: begin
            r_en   <= 1'b1;
            r_rst  <= 1'b1;
            r_modo <= MODO_UP;
          end
          ST_LD_HI: begin
            r_en   <= 1'b1;
            r_rst  <= 1'b0;
            r_modo <= MODO_LOAD;
            r_d    <= LOAD_HI;
          end
          ST_UP: begin
            r_en   <= 1'b1;
            r_rst  <= 1'b0;
            r_modo <= MODO_UP;
          end
          ST_LD_LO: begin
            r_en   <= 1'b1;
            r_rst  <= 1'b0;
            r_modo <= MODO_LOAD;
            r_d    <= LOAD_LO;
          end
          ST_DOWN: begin
            r_en   <= 1'b1;
            r_rst  <= 1'b0;
            r_modo <= MODO_DN;
          end
          ST_DOWN3: begin
            r_en   <= 1'b1;
            r_rst  <= 1'b0;
            r_modo <= MODO_DN3;
          end
          ST_RAND: begin
            r_en   <= w_lfsr[2];
            r_rst  <= 1'b0;
            r_modo <= w_lfsr[1:0];
            r_d    <= w_lfsr;
          end
          default: begin
            r_en   <= 1'b0;
            r_rst  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign D         = r_d;
  assign modo      = r_modo;
  assign enable    = r_en;
  assign dut_reset = r_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign phase     = r_phase;

endmodule

// File: tb/tb_counter32_stimgen.sv
// Bench for counter32_stimgen: per-sequence scoreboard fed by a counter
// model, plus a short-parameter instance checked cycle by cycle.
module tb_counter32_stimgen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] seed = 32'h0;
  logic [31:0] D;
  logic [1:0]  modo;
  logic        enable, dut_reset, busy, done;
  logic [2:0]  phase;

  logic        s_start = 1'b0;
  logic        s_hold = 1'b0;
  logic [31:0] s_seed = 32'h0;
  logic [31:0] s_D;
  logic [1:0]  s_modo;
  logic        s_enable, s_dut_reset, s_busy, s_done;
  logic [2:0]  s_phase;

  always #5 clk = ~clk;

  counter32_stimgen dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .hold(hold), .D(D), .modo(modo), .enable(enable),
    .dut_reset(dut_reset), .busy(busy), .done(done),
    .phase(phase)
  );

  counter32_stimgen #(
    .RST_LEN(1), .PHASE_LEN(1), .RAND_LEN(1)
  ) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .seed(s_seed),
    .hold(s_hold), .D(s_D), .modo(s_modo), .enable(s_enable),
    .dut_reset(s_dut_reset), .busy(s_busy), .done(s_done),
    .phase(s_phase)
  );

  typedef struct {
    int          len;
    logic [31:0] up;
    logic [31:0] dn;
    logic [31:0] d0;
    logic [31:0] d1;
    int          stalls;
    bit          restart;
  } exp_t;

  exp_t exp_q[$];
  int   ph_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int len, input logic [31:0] d0,
                          input logic [31:0] d1, input int st,
                          input bit rs);
    exp_t e;
    e.len = len;
    e.up = 32'h0000_0004;
    e.dn = 32'hFFFF_FFFC;
    e.d0 = d0;
    e.d1 = d1;
    e.stalls = st;
    e.restart = rs;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] cnt_next(
    input logic [31:0] c, input logic r, input logic en,
    input logic [1:0] m, input logic [31:0] d);
    if (r) return 32'h0;
    if (!en) return c;
    case (m)
      2'b00:   return c + 32'd1;
      2'b01:   return c - 32'd1;
      2'b10:   return c - 32'd3;
      default: return d;
    endcase
  endfunction

  // Counter model and per-sequence monitor
  logic [31:0] m_cnt = 32'h0;
  logic [31:0] m_nxt;
  logic [31:0] a_up, a_dn, a_d0, a_d1;
  int          a_len = 0, a_st = 0, a_rn = 0;
  bit          rchk = 1'b0;
  exp_t        e_cur;

  always @(negedge clk) begin
    if (!reset) begin
      m_cnt = 32'h0;
      a_len = 0; a_st = 0; a_rn = 0;
      a_up = 32'h0; a_dn = 32'h0; a_d0 = 32'h0; a_d1 = 32'h0;
      rchk = 1'b0;
    end else begin
      m_nxt = cnt_next(m_cnt, dut_reset, enable, modo, D);
      if (rchk) begin
        chk("restart", {59'h0, done, busy, phase}, 64'b01001);
        rchk = 1'b0;
      end
      if (busy) begin
        a_len++;
        if (phase == 3'd3 && enable) a_up = m_nxt;
        if (phase == 3'd5) begin
          if (enable) a_dn = m_nxt;
          else a_st++;
        end
        if (phase == 3'd7) begin
          if (a_rn == 0) a_d0 = D;
          else if (a_rn == 1) a_d1 = D;
          a_rn++;
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e_cur = exp_q.pop_front();
          chk("seq_len", 64'(a_len), 64'(e_cur.len));
          chk("up_end", 64'(a_up), 64'(e_cur.up));
          chk("down_end", 64'(a_dn), 64'(e_cur.dn));
          chk("rand_d0", 64'(a_d0), 64'(e_cur.d0));
          chk("rand_d1", 64'(a_d1), 64'(e_cur.d1));
          chk("hold_stalls", 64'(a_st), 64'(e_cur.stalls));
          chk("done_busy_en", {62'h0, busy, enable}, 64'h0);
          rchk = e_cur.restart;
        end
        a_len = 0; a_st = 0; a_rn = 0;
      end
      m_cnt = m_nxt;
    end
  end

  always @(negedge clk) begin
    if (reset && (s_busy || s_done)) begin
      if (ph_q.size() == 0) begin
        chk("short_extra", {60'h0, s_done, s_phase}, 64'h0);
      end else begin
        chk("short_phase", {60'h0, s_done, s_phase},
            64'(ph_q.pop_front()));
      end
    end
  end

  task automatic go(input logic [31:0] s);
    seed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_phase(input logic [2:0] p, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (phase == p) return;
    end
    chk("phase_timeout", 64'(phase), 64'(p));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {22'h0, D, modo, enable, dut_reset, busy, done, phase}, 64'h0);
    reset = 1'b1;
    @(negedge clk);

    // Plain run; a start pulse mid-sequence must be ignored
    push_exp(92, 32'hDEADBEEF, 32'hEF76DF74, 0, 1'b0);
    go(32'hDEADBEEF);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    @(negedge clk);

    // Five hold cycles inside DOWN
    push_exp(97, 32'h2, 32'h1, 5, 1'b0);
    go(32'h2);
    wait_phase(3'd5, 100);
    hold = 1'b1;
    repeat (5) @(negedge clk);
    hold = 1'b0;
    wait_done(200);
    @(negedge clk);

    // Zero seed is replaced by 1
    push_exp(92, 32'h1, 32'h8020_0003, 0, 1'b0);
    go(32'h0);
    wait_done(200);
    @(negedge clk);

    // Start held through done: back-to-back sequences
    push_exp(92, 32'h5, 32'h8020_0001, 0, 1'b1);
    push_exp(92, 32'h5, 32'h8020_0001, 0, 1'b0);
    seed = 32'h5;
    start = 1'b1;
    wait_done(200);
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    @(negedge clk);

    // Asynchronous reset in UP: no done, then a clean rerun
    go(32'h77);
    wait_phase(3'd3, 50);
    #2 reset = 1'b0;
    #1 chk("async_reset",
           {22'h0, D, modo, enable, dut_reset, busy, done, phase}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    push_exp(92, 32'hDEADBEEF, 32'hEF76DF74, 0, 1'b0);
    go(32'hDEADBEEF);
    wait_done(200);
    @(negedge clk);

    // Minimum lengths on the second instance
    for (int k = 1; k <= 7; k++) ph_q.push_back(k);
    ph_q.push_back(8);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (12) @(negedge clk);

    chk("exp_q_left", 64'(exp_q.size()), 64'd0);
    chk("ph_q_left", 64'(ph_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter32_stimgen.md
# counter32_stimgen

Synthesizable stimulus sequencer that drives the 32-bit counter interface (`D`, `modo`, `enable`, sync reset) consumed by the 32-bit counter and `scoreboard32`. On `start` it runs a fixed sequence of phases:

- counter reset;
- load near the top, count up through the wrap;
- load near zero, count down through the wrap;
- count down-by-3;
- pseudo-random mode/data traffic.

It then pulses `done`. It sits beside the counter and the scoreboard in the verification harness and in FPGA self-test builds.

## Interface
- `RST_LEN`, 2: cycles of counter reset (1..65535)
- `PHASE_LEN`, 8: cycles in each of UP, DOWN, DOWN3 (1..65535)
- `RAND_LEN`, 64: cycles of random traffic (1..65535)
- `LOAD_HI`, 32'hFFFF_FFFC: value loaded before UP
- `LOAD_LO`, 32'h0000_0004: value loaded before DOWN
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately
- `start`  in  1  begin sequence; sampled only in IDLE
- `seed`  in  32  LFSR seed, captured on accepted `start`
- `hold`  in  1  pause; freezes the sequence
- `D`  out  32  counter load data
- `modo`  out  2  counter mode: 00 up, 01 down, 10 down-by-3, 11 load
- `enable`  out  1  counter enable
- `dut_reset`  out  1  active-high synchronous reset to counter/scoreboard
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse at sequence end
- `phase`  out  3  current state encoding

## Operation
- All outputs are registered.
- Reset value of every output is 0. After reset: state IDLE, LFSR = 32'h1, phase counter = 0.
- States and encodings, run in this order:
  - IDLE(0): `enable`=0, `modo`=00, `D`=0, `dut_reset`=0.
  - RST(1): `enable`=1, `dut_reset`=1, for RST_LEN cycles.
  - LD_HI(2): 1 cycle; `enable`=1, `modo`=11, `D`=LOAD_HI.
  - UP(3): PHASE_LEN cycles; `modo`=00.
  - LD_LO(4): 1 cycle; `modo`=11, `D`=LOAD_LO.
  - DOWN(5): PHASE_LEN cycles; `modo`=01.
  - DOWN3(6): PHASE_LEN cycles; `modo`=10.
  - RAND(7): RAND_LEN cycles, then return to IDLE.
- In all counting phases, `enable`=1 and `D` holds its last value.
- RAND:
  - `D` = current LFSR, `modo` = LFSR[1:0], `enable` = LFSR[2], `dut_reset`=0.
  - The LFSR advances once per RAND cycle.
  - LFSR is a Galois right-shift: next = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 0).
- Seed handling: on accepted `start`, LFSR ← `seed`. A zero seed is replaced by 32'h1.
- Phase counter: 16-bit, counts cycles within a state. It clears on every state change.
- `hold`=1 in any non-IDLE state:
  - forces `enable`=0;
  - freezes state, phase counter and LFSR;
  - leaves `D`, `modo` and `dut_reset` at their current values.
- `hold` in IDLE has no effect.
- `start` while `busy` is ignored.
- `busy` = 1 in every state except IDLE.
- `phase` always equals the state encoding.

## Timing
- `start` is sampled high in IDLE at edge k. From edge k+1: `busy`=1, `phase`=1, `dut_reset`=1.
- Unheld sequence length is RST_LEN+1+PHASE_LEN+1+2·PHASE_LEN+RAND_LEN cycles. With defaults this is 92.
- The cycle after the last RAND cycle: `done`=1 and `busy`=0, both for exactly 1 cycle; `enable`=0.
- A `start` sampled during the `done` cycle is accepted: `done` remains a single pulse and a new sequence begins at the next edge.
- `hold` cycles extend the total length one-for-one. No cycle of any phase is skipped or repeated.
- Reset asserted mid-sequence: outputs go to 0 asynchronously, state becomes IDLE, and no `done` is issued.
- Reset release is synchronous to `clk`.
- With defaults, the counter value after each cycle is:
  - UP: FFFFFFFD, FFFFFFFE, FFFFFFFF, 00000000 (counter rco), 1, 2, 3, 4.
  - DOWN from 4: 3, 2, 1, 0, FFFFFFFF (rco), FFFFFFFE, FFFFFFFD, FFFFFFFC.

## Structure
- Package `counter32_pkg`:
  - `modo` constants: MODO_UP, MODO_DN, MODO_DN3, MODO_LOAD;
  - state enumeration;
  - LFSR polynomial constant 32'h8020_0003.
- Sub-module `lfsr32`:
  - ports: `clk`, `reset`, `load`, `seed`, `advance`, `q`;
  - zero-seed substitution is done inside `lfsr32`.
- Top level: FSM, 16-bit phase counter, output registers.

## Test plan
- Reset low mid-UP (phase=3) → all outputs 0 within the same cycle; `busy`=0; no `done` pulse; a new `start` after release reruns from RST.
- Default parameters, seed 32'hDEADBEEF, `start` one cycle, `hold`=0 → `done` exactly 92 cycles after `start`. A counter fed by the outputs reads 00000004 at the end of UP and FFFFFFFC at the end of DOWN. `scoreboard32` matches the counter every cycle.
- `hold` high for 5 cycles during DOWN → `enable`=0 for those 5 cycles; `phase` stays 5; total length 97; counter end values are unchanged.
- seed = 0 → first RAND `D` = 32'h1; second `D` = 32'h8020_0003.
- `start` pulsed while `busy` → ignored; `start` held high through the `done` cycle → `done` is a single pulse and RST begins on the next cycle.
- RST_LEN=1, PHASE_LEN=1, RAND_LEN=1 → `phase` sequence 1,2,3,4,5,6,7, then `done`; total 7 cycles.
